id_issue: RTL and testbench
===========================

ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 DATA_W, 32, operand/PC/instruction width.
REQ-002 NUM_FWD, 3, forwarding sources; index 0 = youngest (EX), then MEM, WB.
REQ-003 LOAD_LAT, 1, lowest source indices 0..LOAD_LAT-1 whose load data is not yet valid.
REQ-004 STALL_W, 6, stall bus width; this stage owns bit 1, downstream is bit 2.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low: rst=0 at a rising clk edge resets the block.
REQ-007 stall  in  STALL_W  pipeline stall vector.
REQ-008 flush  in  1  discard the instruction in the stage.
REQ-009 if_valid, if_pc  in  1, DATA_W  fetch-stage valid flag and PC.
REQ-010 inst_sram_rdata  in  DATA_W  instruction word, valid one cycle after the fetch that produced if_pc.
REQ-011 rf_rdata1, rf_rdata2  in  DATA_W  regfile read data for rs/rt.
REQ-012 fwd_bus  in  NUM_FWD*(DATA_W+7)  per source {we, is_load, waddr[4:0], wdata}; source i at [i*(DATA_W+7) +: DATA_W+7].
REQ-013 rs_addr, rt_addr  out  5  inst[25:21], inst[20:16] of the presented instruction.
REQ-014 id_valid, id_pc, id_inst  out  1, DATA_W, DATA_W  stage contents.
REQ-015 src1, src2  out  DATA_W  resolved rs/rt operands.
REQ-016 in_delay_slot  out  1  presented instruction follows a branch/jump.
REQ-017 stallreq  out  1  load-use interlock request.

Function
REQ-018 Stage register: stall[1]=1 and stall[2]=0 -> load bubble (valid=0, pc=0); stall[1]=0 -> load if_valid/if_pc; otherwise hold.
REQ-019 flush=1 loads a bubble and overrides REQ-018.
REQ-020 Instruction hold buffer: on the first cycle the stage holds (stall[1]=1), capture inst_sram_rdata into hold_inst and set hold_vld; while hold_vld=1, id_inst=hold_inst, else id_inst=inst_sram_rdata.
REQ-021 hold_vld clears on the edge where stall[1]=0 or flush=1.
REQ-022 id_inst SHALL be 0 when id_valid=0.
REQ-023 Operand resolution per source: pick lowest index i with we=1, waddr=addr, addr!=0; else regfile data; addr=0 yields 0.
REQ-024 stallreq=1 combinationally when id_valid=1 and some source i<LOAD_LAT has we=1, is_load=1, waddr!=0, waddr equal to rs_addr or rt_addr, and no lower index also matches that address.
REQ-025 Interlock is per-address: an older load to a register shadowed by a younger non-load write SHALL NOT stall.
REQ-026 Branch class (opcode 000100, 000101, 000001, 000010, 000011, 000111, 000110, or opcode 0 with func 001000/001001) sets the delay flag when that instruction leaves the stage (stall[1]=0 and id_valid=1).
REQ-027 in_delay_slot reflects the flag for the presented instruction; the flag clears when a valid non-branch leaves, and is unchanged by bubbles.
REQ-028 flush clears the delay flag.
REQ-029 Outputs combinational from stage state; operand latency zero cycles.

Reset
REQ-030 rst=0: id_valid=0, id_pc=0, hold_vld=0, hold_inst=0, delay flag=0, counter=0; thus id_inst=0, in_delay_slot=0, stallreq=0.
REQ-031 Reset overrides flush and stall; reset mid-stall drops the held instruction.

Configuration
REQ-032 ID_STALL_CNT_EN defined: 32-bit output stall_cnt counts cycles with stallreq=1, saturates at 0xFFFFFFFF, clears on reset.
REQ-033 ID_STALL_CNT_EN undefined: port stall_cnt and counter absent; all other behaviour identical.

Verification
REQ-034 Source 0 {we=1,load=0,waddr=5,wdata=0xAAAA0000}, source 1 waddr=5 wdata=0x1, rs=5 -> src1=0xAAAA0000, stallreq=0.
REQ-035 Source 0 load waddr=8, rt=8, id_valid=1 -> stallreq=1; next cycle load in source 1, wdata=0x1234 -> stallreq=0, src2=0x1234.
REQ-036 rs=0 with source 0 we=1 waddr=0 wdata=0xFFFFFFFF -> src1=0, stallreq=0.
REQ-037 stall[1]=1, stall[2]=1 for 3 cycles while inst_sram_rdata changes 0x24020001->0xDEADBEEF -> id_inst stays 0x24020001 throughout.
REQ-038 BEQ leaves, next instruction 0x34210001 presented -> in_delay_slot=1; with flush between them -> in_delay_slot=0.
REQ-039 rst=0 asserted during a 2-cycle interlock -> next cycle id_valid=0, stallreq=0, stall_cnt=0 (with ID_STALL_CNT_EN).

Source files
------------

// File: rtl/id_issue.sv
// -----------------------------------------------------------------------------
// id_issue -- instruction-decode / operand-issue stage.
//
// Holds one instruction between fetch and execute.
// * Stage register: load, hold and bubble control, driven by the stall vector and flush.
// * Instruction hold buffer: keeps the fetched word alive while the stage is held.
// * Operand resolution: picks the youngest forwarding source that writes the
//   register, otherwise the register file. Register 0 always reads as zero.
// * Load-use interlock request.
// * Branch delay-slot flag.
//
// Optional feature, controlled by the macro ID_STALL_CNT_EN:
//   When ID_STALL_CNT_EN is defined, a 32-bit saturating output stall_cnt counts
//   the cycles in which stallreq is high. When the macro is undefined, the port
//   and the counter are absent.
// -----------------------------------------------------------------------------
module id_issue #(
   parameter int DATA_W   = 32,
   parameter int NUM_FWD  = 3,
   parameter int LOAD_LAT = 1,
   parameter int STALL_W  = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [STALL_W-1:0]            stall,
   input  logic                          flush,
   input  logic                          if_valid,
   input  logic [DATA_W-1:0]             if_pc,
   input  logic [DATA_W-1:0]             inst_sram_rdata,
   input  logic [DATA_W-1:0]             rf_rdata1,
   input  logic [DATA_W-1:0]             rf_rdata2,
   input  logic [NUM_FWD*(DATA_W+7)-1:0] fwd_bus,
   output logic [4:0]                    rs_addr,
   output logic [4:0]                    rt_addr,
   output logic                          id_valid,
   output logic [DATA_W-1:0]             id_pc,
   output logic [DATA_W-1:0]             id_inst,
   output logic [DATA_W-1:0]             src1,
   output logic [DATA_W-1:0]             src2,
   output logic                          in_delay_slot,
   output logic                          stallreq
`ifdef ID_STALL_CNT_EN
   ,
   output logic [31:0]                   stall_cnt
`endif
);

   localparam int FW = DATA_W + 7;

   // Forwarding sources, unpacked from the flat bus ({we, is_load, waddr, wdata}).
   logic              fwd_we    [NUM_FWD];
   logic              fwd_ld    [NUM_FWD];
   logic [4:0]        fwd_waddr [NUM_FWD];
   logic [DATA_W-1:0] fwd_wdata [NUM_FWD];

   for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
      assign fwd_we[g]    = fwd_bus[g*FW + DATA_W + 6];
      assign fwd_ld[g]    = fwd_bus[g*FW + DATA_W + 5];
      assign fwd_waddr[g] = fwd_bus[g*FW + DATA_W +: 5];
      assign fwd_wdata[g] = fwd_bus[g*FW +: DATA_W];
   end

   // Only the stall bits owned by this stage and the stage after it matter here.
   logic unused_stall;
   assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

   // Stage state.
   logic              valid_q,     valid_d;
   logic [DATA_W-1:0] pc_q,        pc_d;
   logic              hold_vld_q,  hold_vld_d;
   logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
   logic              dslot_q,     dslot_d;
`ifdef ID_STALL_CNT_EN
   logic [31:0]       cnt_q,       cnt_d;
`endif

   logic              inst_is_branch;
   logic [DATA_W:0]   res_rs, res_rt;

   // Branch class: conditional/unconditional branches, jumps, and jr/jalr.
   function automatic logic is_branch(input logic [31:0] inst);
      logic [5:0] op;
      logic [5:0] fn;
      op = inst[31:26];
      fn = inst[5:0];
      case (op)
         6'b000100, 6'b000101, 6'b000001, 6'b000010,
         6'b000011, 6'b000111, 6'b000110: is_branch = 1'b1;
         6'b000000: is_branch = (fn == 6'b001000) || (fn == 6'b001001);
         default:   is_branch = 1'b0;
      endcase
   endfunction

   // Operand resolution for one register address.
   // Returns {load_pending, data}. The lowest-index (youngest) matching source
   // wins, so the loop walks from oldest to youngest and lets younger matches
   // overwrite older ones.
   function automatic logic [DATA_W:0] resolve(input logic [4:0]        addr,
                                               input logic [DATA_W-1:0] rf);
      logic [DATA_W-1:0] data;
      logic              pend;
      data = rf;
      pend = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && (fwd_waddr[i] == addr)) begin
            data = fwd_wdata[i];
            pend = (i < LOAD_LAT) && fwd_ld[i];
         end
      end
      if (addr == 5'd0) begin
         data = '0;
         pend = 1'b0;
      end
      resolve = {pend, data};
   endfunction

   // Presented instruction, register addresses, resolved operands and the interlock request.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      id_inst = '0;
      if (valid_q) begin
         id_inst = hold_vld_q ? hold_inst_q : inst_sram_rdata;
      end
      rs_addr        = id_inst[25:21];
      rt_addr        = id_inst[20:16];
      inst_is_branch = is_branch(id_inst[31:0]);
      res_rs         = resolve(rs_addr, rf_rdata1);
      res_rt         = resolve(rt_addr, rf_rdata2);
      src1           = res_rs[DATA_W-1:0];
      src2           = res_rt[DATA_W-1:0];
      stallreq       = valid_q && (res_rs[DATA_W] || res_rt[DATA_W]);
   end

   assign id_valid      = valid_q;
   assign id_pc         = pc_q;
   assign in_delay_slot = dslot_q;
`ifdef ID_STALL_CNT_EN
   assign stall_cnt     = cnt_q;
`endif

   // Next-state logic for the stage register, hold buffer, delay flag and counter.
   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      hold_vld_d  = hold_vld_q;
      hold_inst_d = hold_inst_q;
      dslot_d     = dslot_q;

      // Stage register: flush beats everything else. When the stage is stalled
      // and the stage after it is not, a bubble is inserted.
      if (flush) begin
         valid_d = 1'b0;
         pc_d    = '0;
      end else if (stall[1] && !stall[2]) begin
         valid_d = 1'b0;
         pc_d    = '0;
      end else if (!stall[1]) begin
         valid_d = if_valid;
         pc_d    = if_pc;
      end

      // Hold buffer: capture the SRAM word on the first held cycle only.
      if (flush || !stall[1]) begin
         hold_vld_d = 1'b0;
      end else if (!hold_vld_q) begin
         hold_vld_d  = 1'b1;
         hold_inst_d = inst_sram_rdata;
      end

      // Delay flag: updated only when a valid instruction leaves the stage.
      if (flush) begin
         dslot_d = 1'b0;
      end else if (!stall[1] && valid_q) begin
         dslot_d = inst_is_branch;
      end

`ifdef ID_STALL_CNT_EN
      cnt_d = cnt_q;
      if (stallreq && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
`endif
   end

   // State registers with synchronous active-low reset; reset beats flush and stall.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples
      // the pre-edge values of every other flop.
      if (!rst) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         hold_vld_q  <= 1'b0;
         hold_inst_q <= '0;
         dslot_q     <= 1'b0;
`ifdef ID_STALL_CNT_EN
         cnt_q       <= '0;
`endif
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         hold_vld_q  <= hold_vld_d;
         hold_inst_q <= hold_inst_d;
         dslot_q     <= dslot_d;
`ifdef ID_STALL_CNT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_id_issue.sv
// -----------------------------------------------------------------------------
// tb_id_issue -- self-checking bench for id_issue.
// The bench contains a behavioural reference model of the stage. It includes:
// * directed operand vectors, taken from a table;
// * hand-written multi-cycle sequences;
// * a randomized run.
// Checks on stall_cnt are compiled in only when ID_STALL_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_issue;

   localparam int DATA_W   = 32;
   localparam int NUM_FWD  = 3;
   localparam int LOAD_LAT = 1;
   localparam int STALL_W  = 6;
   localparam int FW       = DATA_W + 7;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [STALL_W-1:0]            stall;
   logic                          flush;
   logic                          if_valid;
   logic [DATA_W-1:0]             if_pc;
   logic [DATA_W-1:0]             inst_sram_rdata;
   logic [DATA_W-1:0]             rf_rdata1;
   logic [DATA_W-1:0]             rf_rdata2;
   logic [NUM_FWD*FW-1:0]         fwd_bus;
   logic [4:0]                    rs_addr;
   logic [4:0]                    rt_addr;
   logic                          id_valid;
   logic [DATA_W-1:0]             id_pc;
   logic [DATA_W-1:0]             id_inst;
   logic [DATA_W-1:0]             src1;
   logic [DATA_W-1:0]             src2;
   logic                          in_delay_slot;
   logic                          stallreq;
   logic [31:0]                   stall_cnt;

   id_issue #(
      .DATA_W   (DATA_W),
      .NUM_FWD  (NUM_FWD),
      .LOAD_LAT (LOAD_LAT),
      .STALL_W  (STALL_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .inst_sram_rdata (inst_sram_rdata),
      .rf_rdata1       (rf_rdata1),
      .rf_rdata2       (rf_rdata2),
      .fwd_bus         (fwd_bus),
      .rs_addr         (rs_addr),
      .rt_addr         (rt_addr),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .src1            (src1),
      .src2            (src2),
      .in_delay_slot   (in_delay_slot),
      .stallreq        (stallreq)
`ifdef ID_STALL_CNT_EN
      ,
      .stall_cnt       (stall_cnt)
`endif
   );

`ifndef ID_STALL_CNT_EN
   assign stall_cnt = '0;
`endif

   always #5 clk = ~clk;

   // Forwarding sources as seen by the bench; packed into fwd_bus.
   logic        t_we [NUM_FWD];
   logic        t_ld [NUM_FWD];
   logic [4:0]  t_wa [NUM_FWD];
   logic [31:0] t_wd [NUM_FWD];

   always_comb begin
      fwd_bus = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         fwd_bus[i*FW +: FW] = {t_we[i], t_ld[i], t_wa[i], t_wd[i]};
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The model keeps the following state:
   // * the stage contents: whether it is occupied, and its PC;
   // * the word remembered while the stage is held, if any;
   // * whether the last instruction that left the stage was a branch;
   // * the number of interlock cycles seen.
   bit          m_valid;
   logic [31:0] m_pc;
   bit          m_held;
   logic [31:0] m_hinst;
   bit          m_after_branch;
   longint      m_cnt;

   function automatic bit ref_branch(input logic [31:0] inst);
      logic [5:0] op;
      op = inst[31:26];
      if (op inside {6'h04, 6'h05, 6'h01, 6'h02, 6'h03, 6'h07, 6'h06}) return 1'b1;
      return (op == 6'h00) && (inst[5:0] inside {6'h08, 6'h09});
   endfunction

   function automatic logic [31:0] ref_inst();
      if (!m_valid) return 32'h0;
      return m_held ? m_hinst : inst_sram_rdata;
   endfunction

   // The first source, youngest first, that writes the register supplies it.
   function automatic int first_writer(input logic [4:0] a);
      int w;
      w = -1;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (t_we[i] && t_wa[i] == a) w = i;
      end
      return w;
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
      int w;
      if (a == 5'd0) return 32'h0;
      w = first_writer(a);
      return (w < 0) ? rf : t_wd[w];
   endfunction

   function automatic bit ref_pending(input logic [4:0] a);
      int w;
      if (a == 5'd0) return 1'b0;
      w = first_writer(a);
      return (w >= 0) && (w < LOAD_LAT) && t_ld[w];
   endfunction

   function automatic bit ref_stallreq();
      logic [31:0] inst;
      inst = ref_inst();
      return m_valid && (ref_pending(inst[25:21]) || ref_pending(inst[20:16]));
   endfunction

   // Advance the model by one rising edge using the current inputs.
   task automatic model_step();
      logic [31:0] inst;
      bit          sreq;
      inst = ref_inst();
      sreq = ref_stallreq();
      if (!rst) begin
         m_valid = 0; m_pc = 0; m_held = 0; m_hinst = 0; m_after_branch = 0; m_cnt = 0;
      end else begin
         if (flush) m_after_branch = 0;
         else if (!stall[1] && m_valid) m_after_branch = ref_branch(inst);
         if (flush || !stall[1]) m_held = 0;
         else if (!m_held) begin
            m_held = 1;
            m_hinst = inst_sram_rdata;
         end
         if (flush || (stall[1] && !stall[2])) begin
            m_valid = 0; m_pc = 0;
         end else if (!stall[1]) begin
            m_valid = if_valid; m_pc = if_pc;
         end
         if (sreq && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
   endtask

   // Compare every output against the model.
   task automatic check_all();
      logic [31:0] inst;
      inst = ref_inst();
      check("id_valid", id_valid, m_valid);
      check("id_pc", id_pc, m_pc);
      check("id_inst", id_inst, inst);
      check("rs_addr", rs_addr, inst[25:21]);
      check("rt_addr", rt_addr, inst[20:16]);
      check("src1", src1, ref_operand(inst[25:21], rf_rdata1));
      check("src2", src2, ref_operand(inst[20:16], rf_rdata2));
      check("in_delay_slot", in_delay_slot, m_after_branch);
      check("stallreq", stallreq, ref_stallreq());
`ifdef ID_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_cnt[31:0]);
`endif
   endtask

   // Inputs are driven at posedge+1; outputs are sampled at posedge+3.
   task automatic settle();
      #2;
      check_all();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_src();
      for (int i = 0; i < NUM_FWD; i++) begin
         t_we[i] = 0; t_ld[i] = 0; t_wa[i] = 0; t_wd[i] = 0;
      end
   endtask

   task automatic set_src(input int i, input bit we, input bit ld, input logic [4:0] wa,
                          input logic [31:0] wd);
      t_we[i] = we; t_ld[i] = ld; t_wa[i] = wa; t_wd[i] = wd;
   endtask

   function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, 5'd3, 5'd0, 6'h20};
   endfunction

   // ---------------- operand vector table ----------------
   typedef struct {
      logic [4:0]  rs, rt;
      logic [31:0] rf1, rf2;
      logic [2:0]  we, ld;
      logic [14:0] wa;     // {src2, src1, src0}
      logic [95:0] wd;     // {src2, src1, src0}
      logic [31:0] e1, e2;
      logic        es;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [2:0] we, input logic [2:0] ld,
                               input logic [14:0] wa, input logic [95:0] wd,
                               input logic [31:0] e1, input logic [31:0] e2, input logic es);
      vec_t v;
      v.rs = rs; v.rt = rt; v.rf1 = 32'h11; v.rf2 = 32'h22;
      v.we = we; v.ld = ld; v.wa = wa; v.wd = wd;
      v.e1 = e1; v.e2 = e2; v.es = es;
      return v;
   endfunction

   vec_t vecs [11];

   logic [31:0] pool_op [8];
   logic [5:0]  pool_fn [4];

   initial begin
      logic [31:0] rinst;
      logic [5:0]  op6;

      // ---------- table ----------
      vecs[0]  = mk(5, 3, 3'b011, 3'b000, {5'd0, 5'd5, 5'd5}, {32'h0, 32'h1, 32'hAAAA0000},
                    32'hAAAA0000, 32'h22, 0);                                  // youngest wins
      vecs[1]  = mk(2, 8, 3'b001, 3'b001, {5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h5555},
                    32'h11, 32'h5555, 1);                                      // load-use rt
      vecs[2]  = mk(2, 8, 3'b010, 3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'h1234, 32'h0},
                    32'h11, 32'h1234, 0);                                      // load in MEM
      vecs[3]  = mk(0, 3, 3'b001, 3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hFFFFFFFF},
                    32'h0, 32'h22, 0);                                         // r0 reads 0
      vecs[4]  = mk(9, 9, 3'b011, 3'b010, {5'd0, 5'd9, 5'd9}, {32'h0, 32'hBAD, 32'h77},
                    32'h77, 32'h77, 0);                                        // shadowed load
      vecs[5]  = mk(7, 4, 3'b100, 3'b000, {5'd7, 5'd0, 5'd0}, {32'hCAFE, 32'h0, 32'h0},
                    32'hCAFE, 32'h22, 0);                                      // WB only
      vecs[6]  = mk(7, 7, 3'b110, 3'b000, {5'd7, 5'd7, 5'd0}, {32'h3, 32'h2, 32'h0},
                    32'h2, 32'h2, 0);                                          // MEM over WB
      vecs[7]  = mk(6, 1, 3'b001, 3'b001, {5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h9},
                    32'h9, 32'h22, 1);                                         // load-use rs
      vecs[8]  = mk(6, 6, 3'b000, 3'b111, {5'd6, 5'd6, 5'd6}, {32'h1, 32'h2, 32'h3},
                    32'h11, 32'h22, 0);                                        // we=0 ignored
      vecs[9]  = mk(0, 0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h5},
                    32'h0, 32'h0, 0);                                          // load to r0
      vecs[10] = mk(1, 2, 3'b001, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h44},
                    32'h11, 32'h22, 0);                                        // unrelated load

      pool_op = '{32'h04, 32'h05, 32'h01, 32'h02, 32'h00, 32'h23, 32'h0D, 32'h00};
      pool_fn = '{6'h08, 6'h09, 6'h20, 6'h21};

      // ---------- reset ----------
      rst = 0; stall = '0; flush = 0; if_valid = 1; if_pc = 32'h100;
      inst_sram_rdata = 32'h24020001; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
      clr_src();
      set_src(0, 1, 1, 5'd2, 32'h5);
      advance();
      settle();
      check("reset_id_valid", id_valid, 0);
      check("reset_id_inst", id_inst, 0);
      check("reset_delay", in_delay_slot, 0);
      check("reset_stallreq", stallreq, 0);
      check("reset_id_pc", id_pc, 0);
      advance();

      // ---------- table-driven operand vectors ----------
      rst = 1; clr_src();
      advance();
      for (int k = 0; k < 11; k++) begin
         inst_sram_rdata = r_inst(vecs[k].rs, vecs[k].rt);
         rf_rdata1 = vecs[k].rf1; rf_rdata2 = vecs[k].rf2;
         for (int i = 0; i < NUM_FWD; i++) begin
            set_src(i, vecs[k].we[i], vecs[k].ld[i], vecs[k].wa[i*5 +: 5], vecs[k].wd[i*32 +: 32]);
         end
         settle();
         check($sformatf("vec%0d_src1", k), src1, vecs[k].e1);
         check($sformatf("vec%0d_src2", k), src2, vecs[k].e2);
         check($sformatf("vec%0d_stallreq", k), stallreq, vecs[k].es);
         advance();
      end

      // ---------- load-use, then the load moves on to MEM ----------
      clr_src();
      inst_sram_rdata = r_inst(2, 8);
      set_src(0, 1, 1, 5'd8, 32'h0);
      stall = 6'b000110;
      settle();
      check("lu_stall_on", stallreq, 1);
      advance();
      set_src(0, 0, 0, 5'd0, 32'h0);
      set_src(1, 1, 1, 5'd8, 32'h1234);
      stall = '0;
      settle();
      check("lu_stall_off", stallreq, 0);
      check("lu_src2", src2, 32'h1234);
      advance();

      // ---------- hold buffer keeps the word through a 3-cycle stall ----------
      clr_src();
      inst_sram_rdata = 32'h24020001; if_pc = 32'h200;
      advance();                               // stage loaded
      stall = 6'b000110;
      settle();
      check("hold_first", id_inst, 32'h24020001);
      advance();                               // captured
      inst_sram_rdata = 32'hDEADBEEF;
      for (int c = 0; c < 3; c++) begin
         settle();
         check($sformatf("hold_c%0d", c), id_inst, 32'h24020001);
         advance();
      end
      stall = '0;
      settle();
      check("hold_release", id_inst, 32'h24020001);
      advance();

      // ---------- delay slot: BEQ leaves, then next instruction ----------
      inst_sram_rdata = 32'h10220003;          // BEQ in stage now
      settle();
      advance();                               // BEQ leaves
      inst_sram_rdata = 32'h34210001;
      settle();
      check("dslot_set", in_delay_slot, 1);
      advance();
      settle();
      check("dslot_clear", in_delay_slot, 0);

      // ---------- delay slot cleared by a flush in between ----------
      inst_sram_rdata = 32'h10220003;
      advance();                               // BEQ leaves
      flush = 1;
      settle();
      advance();                               // flush
      flush = 0;
      settle();
      check("flush_bubble", id_valid, 0);
      advance();                               // next instruction loaded
      inst_sram_rdata = 32'h34210001;
      settle();
      check("flush_dslot", in_delay_slot, 0);
      check("flush_valid", id_valid, 1);
      advance();

      // ---------- reset during a 2-cycle interlock ----------
      inst_sram_rdata = r_inst(4, 8);
      set_src(0, 1, 1, 5'd8, 32'h0);
      stall = 6'b000110;
      for (int c = 0; c < 2; c++) begin
         settle();
         check($sformatf("int_stall_c%0d", c), stallreq, 1);
         advance();
      end
      rst = 0;
      settle();
      advance();
      rst = 1;
      settle();
      check("rst_int_valid", id_valid, 0);
      check("rst_int_stallreq", stallreq, 0);
`ifdef ID_STALL_CNT_EN
      check("rst_int_cnt", stall_cnt, 0);
`endif
      stall = '0; clr_src();
      advance();
      settle();
      check("rst_drop_hold", id_inst, inst_sram_rdata);
      advance();

      // ---------- randomized run against the model ----------
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 39) != 0);
         flush    = ($urandom_range(0, 9) == 0);
         stall    = 6'($urandom);
         stall[1] = ($urandom_range(0, 2) == 0);
         if_valid = ($urandom_range(0, 3) != 0);
         if_pc    = $urandom;
         op6      = 6'(pool_op[$urandom_range(0, 7)]);
         rinst    = {op6, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 10'($urandom),
                     pool_fn[$urandom_range(0, 3)]};
         inst_sram_rdata = rinst;
         rf_rdata1 = $urandom;
         rf_rdata2 = $urandom;
         for (int i = 0; i < NUM_FWD; i++) begin
            set_src(i, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
         end
         settle();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
